// File: rtl/ex_lane_latewb_pipe.sv
// Late-writeback pipeline for secondary execute lanes: destinations travel DEPTH stages,
// picking up late functional-unit results at their tagged stage and forwarding each stage.

module ex_lane_latewb_cap #(
   parameter int DATA_W = 64,
   parameter int NSRC   = 4,
   parameter int SEL_W  = 3,
   parameter int STG_W  = 2,
   parameter int STAGE  = 0
) (
   input  logic                   pend,
   input  logic [SEL_W-1:0]       sel,
   input  logic [STG_W-1:0]       stg,
   input  logic [NSRC*DATA_W-1:0] srcVal,
   input  logic [NSRC-1:0]        srcValid,
   output logic                   due,
   output logic                   capture,
   output logic [DATA_W-1:0]      cap_val
);
   logic src_ok;

   // Selects beyond NSRC never match, so such an entry simply never captures.
   always_comb begin
      src_ok  = 1'b0;
      cap_val = '0;
      for (int j = 0; j < NSRC; j++) begin
         if (sel == SEL_W'(j + 1)) begin
            src_ok  = srcValid[j];
            cap_val = srcVal[j*DATA_W +: DATA_W];
         end
      end
   end

   assign due     = pend && (stg == STG_W'(STAGE));
   assign capture = due && src_ok;
endmodule

module ex_lane_latewb_pipe #(
   parameter int DATA_W = 64,
   parameter int ID_W   = 7,
   parameter int DEPTH  = 3,
   parameter int NSRC   = 4,
   parameter logic [ID_W-1:0] ZZR_ID = 7'h3F,
   localparam int SEL_W = $clog2(NSRC + 1),
   localparam int STG_W = $clog2(DEPTH)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    exHold,
   input  logic                    opBraFlush,
   input  logic [ID_W-1:0]         inIdRn,
   input  logic [DATA_W-1:0]       inValRn,
   input  logic [SEL_W-1:0]        inSrcSel,
   input  logic [STG_W-1:0]        inSrcStg,
   input  logic [NSRC*DATA_W-1:0]  srcVal,
   input  logic [NSRC-1:0]         srcValid,
   output logic [DEPTH*ID_W-1:0]   regIdRnS,
   output logic [DEPTH*DATA_W-1:0] regValRnS,
   output logic [DEPTH-1:0]        regHeldS,
   output logic [ID_W-1:0]         regIdRnOut,
   output logic [DATA_W-1:0]       regValRnOut,
   output logic                    exHoldReq,
   output logic                    lateFault
);
   logic [DEPTH-1:0][ID_W-1:0]   id, up_id;
   logic [DEPTH-1:0][DATA_W-1:0] val, up_val, fwd_val, cap_val;
   logic [DEPTH-1:0][SEL_W-1:0]  sel, up_sel;
   logic [DEPTH-1:0][STG_W-1:0]  stg, up_stg;
   logic [DEPTH-1:0]             pend, up_pend, due, cap, miss;

   genvar s;
   generate
      for (s = 0; s < DEPTH; s++) begin : g_stg
         ex_lane_latewb_cap #(
            .DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .STG_W(STG_W), .STAGE(s)
         ) u_cap (
            .pend(pend[s]), .sel(sel[s]), .stg(stg[s]),
            .srcVal(srcVal), .srcValid(srcValid),
            .due(due[s]), .capture(cap[s]), .cap_val(cap_val[s])
         );

         assign fwd_val[s] = cap[s] ? cap_val[s] : val[s];
         assign miss[s]    = due[s] && !cap[s];

         if (s == 0) begin : g_ld
            assign up_id[s]   = opBraFlush ? ZZR_ID : inIdRn;
            assign up_val[s]  = inValRn;
            assign up_pend[s] = !opBraFlush && (inSrcSel != '0);
            assign up_sel[s]  = opBraFlush ? '0 : inSrcSel;
            assign up_stg[s]  = (int'(inSrcStg) >= DEPTH) ? STG_W'(DEPTH - 1) : inSrcStg;
         end else begin : g_sh
            // An entry leaving its capture stage unserved is killed rather than written back.
            assign up_id[s]   = miss[s-1] ? ZZR_ID : id[s-1];
            assign up_val[s]  = fwd_val[s-1];
            assign up_pend[s] = pend[s-1] && !due[s-1];
            assign up_sel[s]  = sel[s-1];
            assign up_stg[s]  = stg[s-1];
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         id        <= {DEPTH{ZZR_ID}};
         val       <= '0;
         pend      <= '0;
         sel       <= '0;
         stg       <= '0;
         lateFault <= 1'b0;
      end else begin
         if (!exHold) begin
            id   <= up_id;
            val  <= up_val;
            pend <= up_pend;
            sel  <= up_sel;
            stg  <= up_stg;
         end else begin
            for (int k = 0; k < DEPTH; k++) begin
               if (cap[k]) begin
                  val[k]  <= cap_val[k];
                  pend[k] <= 1'b0;
               end
            end
         end
         if (!exHold && (|miss)) lateFault <= 1'b1;
      end
   end

   assign regIdRnS    = id;
   assign regValRnS   = fwd_val;
   assign regHeldS    = pend;
   assign regIdRnOut  = (pend[DEPTH-1] && !cap[DEPTH-1]) ? ZZR_ID : id[DEPTH-1];
   assign regValRnOut = fwd_val[DEPTH-1];
   assign exHoldReq   = |miss;
endmodule

// File: tb/tb_ex_lane_latewb_pipe.sv
// Bench for ex_lane_latewb_pipe: directed vector table, reset sequences, and random
// traffic checked against an entry-level model of the lane.

module tb_ex_lane_latewb_pipe;
   localparam int DATA_W = 64;
   localparam int ID_W   = 7;
   localparam int DEPTH  = 3;
   localparam int NSRC   = 4;
   localparam logic [6:0] ZZR = 7'h3F;

   logic                    clock = 1'b0;
   logic                    reset, exHold, opBraFlush;
   logic [ID_W-1:0]         inIdRn;
   logic [DATA_W-1:0]       inValRn;
   logic [2:0]              inSrcSel;
   logic [1:0]              inSrcStg;
   logic [NSRC*DATA_W-1:0]  srcVal;
   logic [NSRC-1:0]         srcValid;
   logic [DEPTH*ID_W-1:0]   regIdRnS;
   logic [DEPTH*DATA_W-1:0] regValRnS;
   logic [DEPTH-1:0]        regHeldS;
   logic [ID_W-1:0]         regIdRnOut;
   logic [DATA_W-1:0]       regValRnOut;
   logic                    exHoldReq, lateFault;

   always #5 clock = ~clock;

   ex_lane_latewb_pipe #(
      .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH), .NSRC(NSRC), .ZZR_ID(ZZR)
   ) dut (
      .clock(clock), .reset(reset), .exHold(exHold), .opBraFlush(opBraFlush),
      .inIdRn(inIdRn), .inValRn(inValRn), .inSrcSel(inSrcSel), .inSrcStg(inSrcStg),
      .srcVal(srcVal), .srcValid(srcValid),
      .regIdRnS(regIdRnS), .regValRnS(regValRnS), .regHeldS(regHeldS),
      .regIdRnOut(regIdRnOut), .regValRnOut(regValRnOut),
      .exHoldReq(exHoldReq), .lateFault(lateFault)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      exHold = 1'b0; opBraFlush = 1'b0; inIdRn = ZZR; inValRn = '0;
      inSrcSel = '0; inSrcStg = '0; srcVal = '0; srcValid = '0;
   endtask

   task automatic load(input logic [6:0] i, input logic [63:0] v, input logic [2:0] sl,
                       input logic [1:0] sg);
      @(negedge clock);
      idle();
      inIdRn = i; inValRn = v; inSrcSel = sl; inSrcStg = sg;
      @(posedge clock);
   endtask

   task automatic chk_cleared(input string tag);
      for (int k = 0; k < DEPTH; k++) begin
         chk($sformatf("%s_id%0d", tag, k), 64'(regIdRnS[k*ID_W +: ID_W]), 64'(ZZR));
         chk($sformatf("%s_val%0d", tag, k), regValRnS[k*DATA_W +: DATA_W], 64'h0);
      end
      chk({tag, "_held"}, 64'(regHeldS), 64'h0);
      chk({tag, "_req"}, 64'(exHoldReq), 64'h0);
      chk({tag, "_fault"}, 64'(lateFault), 64'h0);
      chk({tag, "_outid"}, 64'(regIdRnOut), 64'(ZZR));
      chk({tag, "_outval"}, regValRnOut, 64'h0);
   endtask

   // One row = inputs for a cycle plus the outputs expected just before its clock edge.
   typedef struct {
      bit          hold, flush;
      logic [6:0]  id;
      logic [63:0] val;
      logic [2:0]  sel;
      logic [1:0]  stg;
      logic [3:0]  sv;
      logic [63:0] sval;
      logic [6:0]  e_id;
      logic [63:0] e_val;
      bit          e_req;
      logic [2:0]  e_held;
      bit          e_fault;
      logic [63:0] e_v1;
      bit          ck_v1, ck_ov;
   } vec_t;

   function automatic vec_t v(bit h, bit f, logic [6:0] i, logic [63:0] vl, logic [2:0] sl,
                              logic [1:0] sg, logic [3:0] sv, logic [63:0] svl,
                              logic [6:0] ei, logic [63:0] ev, bit er, logic [2:0] eh,
                              bit ef, logic [63:0] e1, bit c1, bit co);
      vec_t r;
      r.hold = h; r.flush = f; r.id = i; r.val = vl; r.sel = sl; r.stg = sg; r.sv = sv;
      r.sval = svl; r.e_id = ei; r.e_val = ev; r.e_req = er; r.e_held = eh; r.e_fault = ef;
      r.e_v1 = e1; r.ck_v1 = c1; r.ck_ov = co;
      return r;
   endfunction

   typedef struct {
      logic [6:0]  id;
      logic [63:0] val;
      bit          known, pend;
      int          src, cstg;
   } ent_t;

   ent_t        mdl [DEPTH];
   ent_t        nxt;
   bit          mfault;
   bit          rdy [DEPTH];
   bit          got [DEPTH];
   logic [63:0] fv  [DEPTH];
   logic [63:0] svals [NSRC];
   bit          req, hold;
   vec_t        vecs [$];

   initial begin
      //   h f id   val      sel stg sv       sval      | e_id e_val     req held    flt e_v1     c1 co
      vecs.push_back(v(0,0,7'd5, 64'h1234,0,0,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b000,0,64'h0,   1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b000,0,64'h0,   1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b000,0,64'h1234,1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   7'd5,64'h1234,0,3'b000,0,64'h0,   1,1));
      vecs.push_back(v(0,0,7'd9, 64'h0,   2,1,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b000,0,64'h0,   1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b001,0,64'h0,   1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0010,64'hDEAD,ZZR, 64'h0,   0,3'b010,0,64'hDEAD,1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   7'd9,64'hDEAD,0,3'b000,0,64'h0,   1,1));
      vecs.push_back(v(0,0,7'd9, 64'h0,   2,1,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b000,0,64'h0,   1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b001,0,64'h0,   1,1));
      vecs.push_back(v(1,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   ZZR, 64'h0,   1,3'b010,0,64'h0,   1,1));
      vecs.push_back(v(1,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   ZZR, 64'h0,   1,3'b010,0,64'h0,   1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0010,64'hBEEF,ZZR, 64'h0,   0,3'b010,0,64'hBEEF,1,1));
      vecs.push_back(v(0,0,7'd11,64'h11,  0,0,4'b0000,64'h0,   7'd9,64'hBEEF,0,3'b000,0,64'h0,   1,1));
      vecs.push_back(v(0,1,7'd12,64'h77,  0,0,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b000,0,64'h0,   1,1));
      vecs.push_back(v(0,0,7'd13,64'h13,  0,0,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b000,0,64'h11,  1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   7'd11,64'h11, 0,3'b000,0,64'h0,   0,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b000,0,64'h13,  1,0));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   7'd13,64'h13, 0,3'b000,0,64'h0,   1,1));
      vecs.push_back(v(0,0,7'd20,64'h0,   1,1,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b000,0,64'h0,   1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b001,0,64'h0,   1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   ZZR, 64'h0,   1,3'b010,0,64'h0,   1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b000,1,64'h0,   1,1));
      vecs.push_back(v(0,0,ZZR,  64'h0,   0,0,4'b0000,64'h0,   ZZR, 64'h0,   0,3'b000,1,64'h0,   1,1));

      reset = 1'b1;
      idle();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk_cleared("reset");

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         exHold = vecs[i].hold; opBraFlush = vecs[i].flush;
         inIdRn = vecs[i].id; inValRn = vecs[i].val;
         inSrcSel = vecs[i].sel; inSrcStg = vecs[i].stg;
         srcValid = vecs[i].sv; srcVal = {NSRC{vecs[i].sval}};
         #1;
         chk($sformatf("v%0d_outid", i), 64'(regIdRnOut), 64'(vecs[i].e_id));
         if (vecs[i].ck_ov) chk($sformatf("v%0d_outval", i), regValRnOut, vecs[i].e_val);
         chk($sformatf("v%0d_req", i), 64'(exHoldReq), 64'(vecs[i].e_req));
         chk($sformatf("v%0d_held", i), 64'(regHeldS), 64'(vecs[i].e_held));
         chk($sformatf("v%0d_fault", i), 64'(lateFault), 64'(vecs[i].e_fault));
         if (vecs[i].ck_v1) chk($sformatf("v%0d_fwd1", i), regValRnS[DATA_W +: DATA_W], vecs[i].e_v1);
      end

      // Three entries in flight (middle one pending), then a one-cycle reset.
      load(7'd1, 64'hA1, 3'd0, 2'd0);
      load(7'd2, 64'h0,  3'd1, 2'd2);
      load(7'd3, 64'hA3, 3'd0, 2'd0);
      @(negedge clock);
      idle();
      #1;
      chk("mid_held", 64'(regHeldS), 64'b010);
      chk("mid_outid", 64'(regIdRnOut), 64'd1);
      chk("mid_outval", regValRnOut, 64'hA1);
      chk("mid_id0", 64'(regIdRnS[0 +: ID_W]), 64'd3);
      chk("mid_fault", 64'(lateFault), 64'd1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk_cleared("midrst");

      for (int s = 0; s < DEPTH; s++) mdl[s] = '{ZZR, 64'h0, 1'b1, 1'b0, 0, 0};
      mfault = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         reset      = (c % 700 == 699);
         opBraFlush = ($urandom_range(0, 9) == 0);
         inIdRn     = 7'($urandom_range(0, 127));
         inValRn    = {$urandom(), $urandom()};
         inSrcSel   = 3'($urandom_range(0, NSRC));
         inSrcStg   = 2'($urandom_range(0, 3));
         for (int j = 0; j < NSRC; j++) begin
            srcValid[j] = ($urandom_range(0, 9) < 7);
            svals[j]    = {$urandom(), $urandom()};
            srcVal[j*DATA_W +: DATA_W] = svals[j];
         end
         req = 1'b0;
         for (int s = 0; s < DEPTH; s++) begin
            rdy[s] = mdl[s].pend && (mdl[s].cstg == s);
            got[s] = rdy[s] ? srcValid[mdl[s].src - 1] : 1'b0;
            fv[s]  = got[s] ? svals[mdl[s].src - 1] : mdl[s].val;
            if (rdy[s] && !got[s]) req = 1'b1;
         end
         // Mostly follow the stall request; occasionally ignore it to provoke missed captures.
         hold   = ($urandom_range(0, 99) == 0) ? 1'b0 : (req || ($urandom_range(0, 9) == 0));
         exHold = hold;
         #1;
         for (int s = 0; s < DEPTH; s++) begin
            chk($sformatf("r%0d_id%0d", c, s), 64'(regIdRnS[s*ID_W +: ID_W]), 64'(mdl[s].id));
            chk($sformatf("r%0d_held%0d", c, s), 64'(regHeldS[s]), 64'(mdl[s].pend));
            if (mdl[s].known || got[s])
               chk($sformatf("r%0d_val%0d", c, s), regValRnS[s*DATA_W +: DATA_W], fv[s]);
         end
         chk($sformatf("r%0d_outid", c), 64'(regIdRnOut),
             64'((mdl[DEPTH-1].pend && !got[DEPTH-1]) ? ZZR : mdl[DEPTH-1].id));
         if (mdl[DEPTH-1].known || got[DEPTH-1])
            chk($sformatf("r%0d_outval", c), regValRnOut, fv[DEPTH-1]);
         chk($sformatf("r%0d_req", c), 64'(exHoldReq), 64'(req));
         chk($sformatf("r%0d_fault", c), 64'(lateFault), 64'(mfault));
         @(posedge clock);
         if (reset) begin
            for (int s = 0; s < DEPTH; s++) mdl[s] = '{ZZR, 64'h0, 1'b1, 1'b0, 0, 0};
            mfault = 1'b0;
         end else if (hold) begin
            for (int s = 0; s < DEPTH; s++)
               if (got[s]) begin
                  mdl[s].val = fv[s]; mdl[s].known = 1'b1; mdl[s].pend = 1'b0;
               end
         end else begin
            for (int s = 0; s < DEPTH; s++) if (rdy[s] && !got[s]) mfault = 1'b1;
            for (int s = DEPTH - 1; s > 0; s--) begin
               nxt = mdl[s-1];
               if (got[s-1]) begin
                  nxt.val = fv[s-1]; nxt.known = 1'b1; nxt.pend = 1'b0;
               end else if (rdy[s-1]) begin
                  nxt.id = ZZR; nxt.pend = 1'b0;
               end
               mdl[s] = nxt;
            end
            mdl[0].id    = opBraFlush ? ZZR : inIdRn;
            mdl[0].val   = inValRn;
            mdl[0].known = !opBraFlush;
            mdl[0].pend  = !opBraFlush && (inSrcSel != 0);
            mdl[0].src   = int'(inSrcSel);
            mdl[0].cstg  = (int'(inSrcStg) >= DEPTH) ? DEPTH - 1 : int'(inSrcStg);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_lane_latewb_pipe.md
Name: ex_lane_latewb_pipe

Overview:
- Parametrised late-writeback pipeline for secondary execute lanes (lane 2+).
- Generalises the fixed single-stage EX2 result select: each destination entering the lane carries either a ready value or a tag naming which late functional-unit result it needs and at which stage.
- Over DEPTH stages it captures late results, stalls when a result is missing, squashes on branch flush, and exposes per-stage forwarding (id, value, held) to the register-file bypass network.

Parameters:
DATA_W, 64, result value width
ID_W, 7, GPR id width
DEPTH, 3, number of pipeline stages (2..6)
NSRC, 4, number of late result sources (ALU, MULW, FPU, delay-path)
ZZR_ID, 7'h3F, null destination id (ZZR)

Ports:
clock  in  1  core clock
reset  in  1  synchronous active-high reset
exHold  in  1  pipeline freeze from core hold logic
opBraFlush  in  1  squash the entry being loaded this cycle
inIdRn  in  ID_W  destination id entering stage 0
inValRn  in  DATA_W  ready value (used when inSrcSel==0)
inSrcSel  in  SEL_W=$clog2(NSRC+1)  0=value ready; k=take source k-1
inSrcStg  in  STG_W=$clog2(DEPTH)  stage index at which source is captured
srcVal  in  NSRC*DATA_W  late result values, source j at [j*DATA_W +: DATA_W]
srcValid  in  NSRC  source j result valid this cycle
regIdRnS  out  DEPTH*ID_W  per-stage forwarding id
regValRnS  out  DEPTH*DATA_W  per-stage forwarding value
regHeldS  out  DEPTH  per-stage "value not yet available"
regIdRnOut  out  ID_W  final-stage writeback id
regValRnOut  out  DATA_W  final-stage writeback value
exHoldReq  out  1  stall request (combinational)
lateFault  out  1  sticky: an entry left its capture stage still pending

Behaviour:
- Per stage s: id, val, pend, sel, stg registers.
- Reset (synchronous): all id=ZZR_ID, val=0, pend=0, sel=0, stg=0, lateFault=0. Outputs then show ZZR ids, zero values, held=0, exHoldReq=0.
- Load (stage 0, when !exHold):
  - id=inIdRn, val=inValRn, pend=(inSrcSel!=0).
  - inSrcStg>=DEPTH is clamped to DEPTH-1.
  - If opBraFlush: id=ZZR_ID, pend=0 (value don't-care).
- Shift: when !exHold, stage s+1 takes stage s on the clock edge. When exHold, all stages keep their contents.
- Capture: applies to stage s when pend && stg==s && srcValid[sel-1].
  - Stage writes val=srcVal[sel-1], pend=0.
  - Happens every such cycle, including while exHold=1.
  - If !exHold, the captured value moves to s+1 with pend=0 on the same edge.
- exHoldReq = OR over stages of (pend && stg==s && !srcValid[sel-1]).
  - Core is expected to feed this into exHold; this block does not self-hold.
- Missed capture: if an entry shifts out of stage s while pend && stg==s (exHold ignored):
  - Destination becomes ZZR_ID, pend=0.
  - lateFault set; it is sticky until reset.
- Forwarding outputs:
  - regHeldS[s]=pend.
  - regValRnS[s]=val, or the srcVal being captured that cycle when capture applies (same-cycle bypass).
  - regIdRnS[s]=id.
- Final outputs: regIdRnOut/regValRnOut mirror stage DEPTH-1 forwarding values. Id is forced to ZZR_ID if that stage is still pending.
- Simultaneous events:
  - flush with exHold=1: no load, and flush has no effect on held contents.
  - Capture and shift on the same edge: capture wins, the value is carried forward.
- Latency: ready values appear at regIdRnOut DEPTH cycles after load with no holds.

Test Plan:
- Ready value, DEPTH=3: load id=5, val=0x1234, sel=0 -> regIdRnOut=5, regValRnOut=0x1234 at cycle 3; regHeldS always 0.
- Late capture: id=9, sel=2, stg=1, srcValid[1]=1 with srcVal=0xDEAD when the entry reaches stage 1 -> stage1 forwards 0xDEAD same cycle; regIdRnOut=9 with 0xDEAD one cycle later; exHoldReq never set.
- Missing source: as above but srcValid[1]=0 for 2 cycles, exHold=exHoldReq -> exHoldReq=1 for 2 cycles, pipeline frozen, regHeldS[1]=1; source valid on 3rd cycle -> captured, shift resumes, lateFault=0.
- Branch flush: load id=12 with opBraFlush=1 -> id ZZR (0x3F) at all stages; adjacent entries unaffected.
- Fault path: pending entry at capture stage, srcValid=0, exHold forced 0 -> output id=0x3F, lateFault=1 and sticky; reset -> lateFault=0, all ids 0x3F.
- Reset mid-operation: 3 valid entries in flight, assert reset 1 cycle -> next cycle all ids 0x3F, values 0, held 0.
